// File: rtl/draw_car.sv
// draw_car: overlays a car sprite from an external ROM onto a VGA pixel stream.
// Two-stage pipeline: stage 1 tests the sprite window and issues the ROM address,
// stage 2 picks either the ROM pixel or the background pixel.
// The ROM read is expected to be look-ahead: pixel_rgb belongs to the address
// registered on the previous pclk edge, so stage 2 can use it directly.
// Optional feature: define DRAW_CAR_COLLISION_EN to add the per-frame
// collision flag (sprite drawn over an OBST_RGB background pixel).
// VGA bus layout, MSB first: {hsync, vsync, hblnk, vblnk, hcount[10:0], vcount[10:0], rgb[11:0]}.

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module draw_car #(
    parameter int          CAR_W    = 32,
    parameter int          CAR_H    = 64,
    parameter logic [11:0] KEY_RGB  = 12'h0F0,
    parameter logic [11:0] OBST_RGB = 12'hFFF
) (
    input  logic                            pclk,
    input  logic                            rst_n,
    input  logic [`VGA_BUS_SIZE-1:0]        vga_in,
    input  logic [10:0]                     xpos,
    input  logic [10:0]                     ypos,
    input  logic [11:0]                     pixel_rgb,
    output logic [`VGA_BUS_SIZE-1:0]        vga_out,
    output logic [$clog2(CAR_W*CAR_H)-1:0]  pixel_addr
`ifdef DRAW_CAR_COLLISION_EN
    ,
    output logic                            collision
`endif
);

    // Sprite address split: row index in the upper bits, column in the lower bits.
    // Both dimensions are powers of two (at least 2), so the address is a plain concatenation.
    localparam int XB     = $clog2(CAR_W);
    localparam int YB     = $clog2(CAR_H);
    localparam int ADDR_W = $clog2(CAR_W*CAR_H);

    // Field positions inside the VGA bus.
    localparam int HSYNC_BIT = 37;
    localparam int VSYNC_BIT = 36;
    localparam int HBLNK_BIT = 35;
    localparam int VBLNK_BIT = 34;
    localparam int HC_LSB    = 23;
    localparam int VC_LSB    = 12;
    localparam int RGB_LSB   = 0;

    localparam logic [11:0] CAR_W12 = 12'(CAR_W);
    localparam logic [11:0] CAR_H12 = 12'(CAR_H);

    // ------------------------------------------------------------------
    // Input field decode
    // ------------------------------------------------------------------
    logic        w_in_vsync;
    logic [10:0] w_in_hcount;
    logic [10:0] w_in_vcount;

    assign w_in_vsync  = vga_in[VSYNC_BIT];
    assign w_in_hcount = vga_in[HC_LSB +: 11];
    assign w_in_vcount = vga_in[VC_LSB +: 11];

    // ------------------------------------------------------------------
    // Frame-synchronous position latch
    // ------------------------------------------------------------------
    logic        r_vsync_prev;
    logic [10:0] r_x_act;
    logic [10:0] r_y_act;
    logic        w_vs_rise;

    assign w_vs_rise = w_in_vsync & ~r_vsync_prev;

    // Latch the requested position only on a vsync rising edge so the sprite never tears mid-frame.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_prev <= 1'b0;
            r_x_act      <= '0;
            r_y_act      <= '0;
        end else begin
            r_vsync_prev <= w_in_vsync;
            if (w_vs_rise) begin
                r_x_act <= xpos;
                r_y_act <= ypos;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: window test and ROM address
    // ------------------------------------------------------------------
    logic [11:0]       w_h12;
    logic [11:0]       w_v12;
    logic [11:0]       w_x12;
    logic [11:0]       w_y12;
    logic              w_in_win;
    logic [XB-1:0]     w_dx;
    logic [YB-1:0]     w_dy;
    logic [ADDR_W-1:0] w_addr;

    // One extra bit keeps x_act+CAR_W from wrapping back to low columns near 2047.
    assign w_h12 = {1'b0, w_in_hcount};
    assign w_v12 = {1'b0, w_in_vcount};
    assign w_x12 = {1'b0, r_x_act};
    assign w_y12 = {1'b0, r_y_act};

    assign w_in_win = (w_h12 >= w_x12) && (w_h12 < (w_x12 + CAR_W12)) &&
                      (w_v12 >= w_y12) && (w_v12 < (w_y12 + CAR_H12));

    // Only the low bits of the offsets matter; they depend only on the low bits of the operands.
    assign w_dx   = w_in_hcount[XB-1:0] - r_x_act[XB-1:0];
    assign w_dy   = w_in_vcount[YB-1:0] - r_y_act[YB-1:0];
    assign w_addr = w_in_win ? {w_dy, w_dx} : '0;

    logic [`VGA_BUS_SIZE-1:0] r_bus_d1;
    logic                     r_in_win_d1;

    // Stage-1 register: delay the whole bus and capture window flag plus ROM address.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_d1    <= '0;
            r_in_win_d1 <= 1'b0;
            pixel_addr  <= '0;
        end else begin
            r_bus_d1    <= vga_in;
            r_in_win_d1 <= w_in_win;
            pixel_addr  <= w_addr;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour select
    // ------------------------------------------------------------------
    logic        w_draw;
    logic [11:0] w_bg_rgb;
    logic [11:0] w_rgb_sel;

    assign w_bg_rgb = r_bus_d1[RGB_LSB +: 12];

    // Opaque sprite pixel inside the window and outside both blanking intervals.
    assign w_draw = r_in_win_d1 &
                    ~r_bus_d1[HBLNK_BIT] &
                    ~r_bus_d1[VBLNK_BIT] &
                    (pixel_rgb != KEY_RGB);

    assign w_rgb_sel = w_draw ? pixel_rgb : w_bg_rgb;

    // Stage-2 register: timing fields pass straight through, rgb is replaced where the sprite is drawn.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vga_out <= '0;
        end else begin
            vga_out <= {r_bus_d1[HSYNC_BIT], r_bus_d1[VSYNC_BIT],
                        r_bus_d1[HBLNK_BIT], r_bus_d1[VBLNK_BIT],
                        r_bus_d1[HC_LSB +: 11], r_bus_d1[VC_LSB +: 11],
                        w_rgb_sel};
        end
    end

`ifdef DRAW_CAR_COLLISION_EN
    // ------------------------------------------------------------------
    // Optional per-frame collision detection
    // ------------------------------------------------------------------
    logic w_hit;
    logic r_coll_acc;

    assign w_hit = w_draw & (w_bg_rgb == OBST_RGB);

    // Sticky hit accumulator, published and cleared at each vsync rising edge (clear wins over a hit).
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_coll_acc <= 1'b0;
            collision  <= 1'b0;
        end else if (w_vs_rise) begin
            collision  <= r_coll_acc;
            r_coll_acc <= 1'b0;
        end else if (w_hit) begin
            r_coll_acc <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_draw_car.sv
// tb_draw_car: directed self-checking bench for draw_car on 800x600 timing.
// Only the pixels of interest are driven; the design holds no state besides the
// pipeline and the vsync edge, so lines and frames are entered by jumping hcount/vcount.
`timescale 1ns/1ps

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module tb_draw_car;

    localparam int BW = `VGA_BUS_SIZE;

    logic          pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] vga_in = '0;
    logic [10:0]   xpos = '0;
    logic [10:0]   ypos = '0;
    logic [11:0]   pixel_rgb;
    logic [BW-1:0] vga_out;
    logic [10:0]   pixel_addr;
`ifdef DRAW_CAR_COLLISION_EN
    logic          collision;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int rom_mode = 0;   // 0: all zero, 1: data = address, 2: KEY_RGB for addresses 0-31, else address

    always #5 pclk = ~pclk;

    // Look-ahead sprite ROM model.
    always_comb begin
        pixel_rgb = 12'h000;
        case (rom_mode)
            1: pixel_rgb = {1'b0, pixel_addr};
            2: pixel_rgb = (pixel_addr < 11'd32) ? 12'h0F0 : {1'b0, pixel_addr};
            default: pixel_rgb = 12'h000;
        endcase
    end

    draw_car dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .vga_in     (vga_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .pixel_rgb  (pixel_rgb),
        .vga_out    (vga_out),
        .pixel_addr (pixel_addr)
`ifdef DRAW_CAR_COLLISION_EN
        ,
        .collision  (collision)
`endif
    );

    // Build one 800x600 (SVGA 40 MHz) bus word for pixel (h,v).
    function automatic logic [BW-1:0] mk(input int h, input int v, input logic [11:0] rgb);
        logic hs, vs, hb, vb;
        hs = (h >= 840) && (h < 968);
        vs = (v >= 601) && (v < 605);
        hb = (h >= 800);
        vb = (v >= 600);
        return {hs, vs, hb, vb, 11'(h), 11'(v), rgb};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
    endtask

    // Drive one pixel, follow it with a blanking filler, and check its rgb two pclk later.
    task automatic probe(input string tag, input int h, input int v,
                         input logic [11:0] bg, input logic [11:0] exp);
        vga_in = mk(h, v, bg);
        tick();
        vga_in = mk(900, v, 12'h000);
        tick();
        chk(tag, {52'd0, vga_out[11:0]}, {52'd0, exp});
    endtask

    // Produce one vsync rising edge (loads xpos/ypos into the active position).
    task automatic new_frame();
        vga_in = mk(0, 600, 12'h000);
        tick();
        vga_in = mk(0, 601, 12'h000);
        tick();
        vga_in = mk(0, 605, 12'h000);
        tick();
    endtask

    logic [BW-1:0] prev_bus;

    initial begin
        // Reset: outputs held at zero while the bus toggles.
        xpos = 11'd1000;
        ypos = 11'd700;
        rom_mode = 0;
        for (int i = 0; i < 4; i++) begin
            vga_in = mk(400 + i, 300, 12'(i * 273 + 5));
            tick();
            chk("rst_vga_out", {26'd0, vga_out}, 64'd0);
            chk("rst_addr", {53'd0, pixel_addr}, 64'd0);
        end
`ifdef DRAW_CAR_COLLISION_EN
        chk("rst_collision", {63'd0, collision}, 64'd0);
`endif

        // Release mid-line; stream crosses into horizontal blanking.
        rst_n = 1'b1;
        prev_bus = '0;
        for (int i = 0; i < 24; i++) begin
            vga_in = mk(790 + i, 300, 12'(i * 151 + 3));
            tick();
            if (i == 0) chk("rel_first", {26'd0, vga_out}, 64'd0);
            else        chk("lat2", {26'd0, vga_out}, {26'd0, prev_bus});
            prev_bus = vga_in;
        end

        // Before the first vsync edge the sprite sits at (0,0).
        probe("pre_vs_origin", 5, 5, 12'h123, 12'h000);
        new_frame();
        probe("offscr_origin", 5, 5, 12'h123, 12'h123);
        probe("offscr_pos", 1005, 705, 12'h321, 12'h321);

        // Basic draw and neighbours.
        rom_mode = 1;
        xpos = 11'd100;
        ypos = 11'd200;
        new_frame();
        probe("draw_tl", 100, 200, 12'hABC, 12'h000);
        probe("draw_br", 131, 263, 12'hABC, 12'h7FF);
        probe("nb_left", 99, 200, 12'hABC, 12'hABC);
        probe("nb_right", 132, 200, 12'hABC, 12'hABC);
        probe("nb_above", 100, 199, 12'hABC, 12'hABC);
        probe("nb_below", 131, 264, 12'hABC, 12'hABC);

        // Transparency.
        rom_mode = 2;
        probe("key_row0", 110, 200, 12'hABC, 12'hABC);
        probe("key_row1", 110, 201, 12'hABC, 12'h02A);

        // Frame-synchronous move.
        rom_mode = 1;
        xpos = 11'd300;
        probe("mv_old_still", 100, 210, 12'hABC, 12'h140);
        probe("mv_new_early", 300, 210, 12'hABC, 12'hABC);
        new_frame();
        probe("mv_new", 300, 210, 12'hABC, 12'h140);
        probe("mv_old_gone", 100, 210, 12'hABC, 12'hABC);

        // Clipping at the bottom-right corner.
        xpos = 11'd790;
        ypos = 11'd590;
        new_frame();
        probe("clip_tl", 790, 590, 12'hABC, 12'h000);
        probe("clip_mid", 795, 595, 12'hABC, 12'h0A5);
        probe("clip_br", 799, 599, 12'hABC, 12'h129);
        probe("clip_hblank", 800, 590, 12'h555, 12'h555);
        probe("clip_vblank", 790, 600, 12'h555, 12'h555);
        probe("clip_nowrap0", 0, 590, 12'hABC, 12'hABC);
        probe("clip_nowrap1", 1, 595, 12'hABC, 12'hABC);

        // Window compare near 2047 must not wrap.
        xpos = 11'd2040;
        ypos = 11'd0;
        new_frame();
        vga_in = mk(2045, 0, 12'h555);
        tick();
        chk("addr_12bit", {53'd0, pixel_addr}, 64'd5);
        vga_in = mk(900, 0, 12'h000);
        tick();
        chk("edge_blank_rgb", {52'd0, vga_out[11:0]}, {52'd0, 12'h555});

`ifdef DRAW_CAR_COLLISION_EN
        // Collision: opaque pixel over an obstacle pixel.
        xpos = 11'd100;
        ypos = 11'd200;
        new_frame();
        chk("coll_before", {63'd0, collision}, 64'd0);
        probe("coll_pix", 110, 210, 12'hFFF, 12'h14A);
        new_frame();
        chk("coll_set", {63'd0, collision}, 64'd1);
        probe("coll_miss", 110, 210, 12'hABC, 12'h14A);
        new_frame();
        chk("coll_clear", {63'd0, collision}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
